// File: rtl/risc_mem_system.sv
// risc_mem_system: instruction ROM, byte-lane data RAM with programmable wait
// states, a GPIO output register and a free-running cycle counter, all behind
// a single req/ready data port that lets the core stall.
module risc_mem_system #(
  parameter int          IMEM_DEPTH  = 256,
  parameter int          DMEM_DEPTH  = 256,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] GPIO_ADDR   = 32'h0000_1000,
  parameter logic [31:0] CNT_ADDR    = 32'h0000_1004,
  parameter string       IMEM_FILE   = "imem.hex"
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic [31:0] instr,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic        d_unsigned,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        d_err,
  output logic [31:0] gpio_out
);
  localparam int IW = $clog2(IMEM_DEPTH);
  localparam int DW = $clog2(DMEM_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      r_state;
  logic [2:0]  r_wcnt;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_uns;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_ready;
  logic        r_err;
  logic [31:0] r_rdata;
  logic [31:0] r_gpio;
  logic [31:0] r_counter;

  // ROM image (IMEM_FILE) is placed by the build / simulation environment;
  // the fabric never writes it.
  logic [31:0] r_rom [IMEM_DEPTH];
  logic [31:0] r_ram [DMEM_DEPTH];

  logic        w_idle;
  logic        w_we;
  logic [1:0]  w_size;
  logic        w_uns;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic [31:0] w_waddr;
  logic        w_is_gpio;
  logic        w_is_cnt;
  logic        w_is_ram;
  logic [DW-1:0] w_ram_idx;
  logic [31:0] w_src;
  logic        w_misal;
  logic        w_enter;
  logic        w_store;
  logic [3:0]  w_be;
  logic [31:0] w_wrep;
  logic [31:0] w_merged;
  logic [15:0] w_shift;
  logic [31:0] w_load;
  logic        w_unused_pc;

  // Fetch path: word-indexed, wraps modulo ROM depth.
  assign instr       = r_rom[pc[IW+1:2]];
  assign w_unused_pc = ^{pc[31:IW+2], pc[1:0]};

  // On the accepting edge the live inputs describe the access; afterwards the
  // latched copy does, so late input changes cannot disturb it.
  assign w_idle  = (r_state == S_IDLE);
  assign w_we    = w_idle ? d_we       : r_we;
  assign w_size  = w_idle ? d_size     : r_size;
  assign w_uns   = w_idle ? d_unsigned : r_uns;
  assign w_addr  = w_idle ? d_addr     : r_addr;
  assign w_wdata = w_idle ? d_wdata    : r_wdata;

  assign w_waddr   = {w_addr[31:2], 2'b00};
  assign w_is_gpio = (w_waddr == GPIO_ADDR);
  assign w_is_cnt  = (w_waddr == CNT_ADDR);
  assign w_is_ram  = !w_is_gpio && !w_is_cnt;
  assign w_ram_idx = w_addr[DW+1:2];
  assign w_src     = w_is_gpio ? r_gpio : (w_is_cnt ? r_counter : r_ram[w_ram_idx]);

  assign w_misal = ((w_size == 2'b01) && w_addr[0]) || (w_size[1] && (w_addr[1:0] != 2'b00));

  // Edge on which the FSM moves into RESP: stores commit and load data is captured.
  // Gated by reset so an access in flight is dropped when reset is asserted.
  assign w_enter = reset && ((w_idle && d_req && (WAIT_STATES == 0)) ||
                             ((r_state == S_WAIT) && (r_wcnt == 3'd1)));
  assign w_store = w_enter && w_we && !w_misal;

  // Byte-enable and lane-replicated store data from size and low address bits.
  always_comb begin
    w_be   = 4'b1111;
    w_wrep = w_wdata;
    case (w_size)
      2'b00: begin
        w_be   = 4'b0001 << w_addr[1:0];
        w_wrep = {4{w_wdata[7:0]}};
      end
      2'b01: begin
        w_be   = w_addr[1] ? 4'b1100 : 4'b0011;
        w_wrep = {2{w_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Read-modify-write merge of the enabled lanes into the target word.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign w_merged[gi*8 +: 8] = w_be[gi] ? w_wrep[gi*8 +: 8] : w_src[gi*8 +: 8];
  end

  // Load alignment: move the addressed byte/half to bit 0 and extend it.
  always_comb begin
    w_shift = 16'(w_src >> {w_addr[1:0], 3'b000});
    case (w_size)
      2'b00:   w_load = {{24{~w_uns & w_shift[7]}}, w_shift[7:0]};
      2'b01:   w_load = {{16{~w_uns & w_shift[15]}}, w_shift[15:0]};
      default: w_load = w_src;
    endcase
  end

  // Access FSM with registered response outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_wcnt  <= 3'd0;
      r_we    <= 1'b0;
      r_size  <= 2'b00;
      r_uns   <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (d_req) begin
            r_we    <= d_we;
            r_size  <= d_size;
            r_uns   <= d_unsigned;
            r_addr  <= d_addr;
            r_wdata <= d_wdata;
            if (WAIT_STATES == 0) begin
              r_state <= S_RESP;
            end else begin
              r_wcnt  <= 3'(WAIT_STATES);
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          r_wcnt <= r_wcnt - 3'd1;
          if (r_wcnt == 3'd1) r_state <= S_RESP;
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_enter) begin
        r_ready <= 1'b1;
        r_err   <= w_misal;
        r_rdata <= (w_we || w_misal) ? 32'd0 : w_load;
      end
    end
  end

  // Free-running cycle counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_counter <= 32'd0;
    else        r_counter <= r_counter + 32'd1;
  end

  // GPIO output register, written lane-wise by stores to its address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                     r_gpio <= 32'd0;
    else if (w_store && w_is_gpio)  r_gpio <= w_merged;
  end

  // Data RAM write port (contents survive reset).
  always_ff @(posedge clk) begin
    if (w_store && w_is_ram) r_ram[w_ram_idx] <= w_merged;
  end

  assign d_ready  = r_ready;
  assign d_err    = r_err;
  assign d_rdata  = r_rdata;
  assign gpio_out = r_gpio;
endmodule

// File: doc/risc_mem_system.md
Name: risc_mem_system

Overview:
Parametrised memory subsystem for the RISC-V core, replacing the fixed single-cycle instruction and data memories. It contains four things:
- instruction ROM;
- word-organised data RAM with byte/half/word access and configurable wait states;
- req/ready handshake so the core can stall;
- memory-mapped GPIO output register and free-running cycle counter.

The block sits between the core and the top-level pins.

Parameters:
IMEM_DEPTH, 256, instruction ROM depth in 32-bit words (power of 2)
DMEM_DEPTH, 256, data RAM depth in 32-bit words (power of 2)
WAIT_STATES, 1, extra cycles before a data response (0..7)
GPIO_ADDR, 32'h0000_1000, word address of GPIO output register
CNT_ADDR, 32'h0000_1004, word address of cycle counter (read-only)
IMEM_FILE, "imem.hex", $readmemh init file for ROM

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
pc  in  32  instruction fetch address
instr  out  32  instruction word
d_req  in  1  data access request
d_we  in  1  1 = store, 0 = load
d_size  in  2  00 byte, 01 half, 10 word (11 treated as word)
d_unsigned  in  1  zero-extend loads when 1, else sign-extend
d_addr  in  32  byte address
d_wdata  in  32  store data, right-aligned
d_rdata  out  32  load result, extended
d_ready  out  1  one-cycle response strobe
d_err  out  1  misaligned-access flag, valid with d_ready
gpio_out  out  32  GPIO output register

Behaviour:
- Reset (reset=0, asynchronous) clears these: d_ready=0, d_err=0, d_rdata=0, gpio_out=0, counter=0, FSM=IDLE. RAM and ROM contents are not reset.
- Reset mid-transaction aborts it; no RAM or GPIO write occurs.
- Instruction path is combinational:
  - instr = ROM[pc[log2(IMEM_DEPTH)+1:2]];
  - pc[1:0] ignored;
  - out-of-range addresses wrap modulo depth.
- Cycle counter increments every clock when out of reset and wraps 32'hFFFF_FFFF -> 0.
- FSM states are IDLE, WAIT, RESP.
  - IDLE: on a clock edge with d_req=1, latch d_we/d_size/d_unsigned/d_addr/d_wdata. If WAIT_STATES=0, go to RESP; else load wait count = WAIT_STATES and go to WAIT.
  - WAIT: decrement the count each cycle; go to RESP on the edge where the count reaches 0.
  - RESP: d_ready=1 for exactly one cycle, then go to IDLE unconditionally. d_req sampled in RESP is ignored, so there is at least one IDLE cycle between transactions.
- Load-to-ready latency is WAIT_STATES+1 cycles after the accepting edge.
- Input changes after acceptance are ignored; the latched copy is used.
- Store commit: RAM/GPIO are written on the edge that enters RESP, using byte lanes:
  - byte: lane addr[1:0];
  - half: lanes {addr[1],0} and {addr[1],1};
  - word: all lanes.
- Load data: d_rdata is updated on the edge entering RESP and holds until the next response.
  1. Select the addressed byte/half/word.
  2. Shift it to bit 0.
  3. Extend it per d_unsigned.
  - For stores, d_rdata = 0.
- Misalignment: half with addr[0]=1, or word with addr[1:0]≠0.
  - d_err=1 in RESP.
  - No write occurs.
  - d_rdata=0.
  - Timing is identical to a normal access.
- Address decode uses the word address {addr[31:2],2'b00}:
  - equal to GPIO_ADDR: GPIO register; stores use byte lanes; loads return gpio_out, extended.
  - equal to CNT_ADDR: loads return the counter value sampled at the RESP-entry edge; stores are silently dropped with no error.
  - all other addresses: RAM at index addr[log2(DMEM_DEPTH)+1:2], wrapping modulo depth.
- d_err and d_ready are both 0 outside RESP.

Test Plan:
- Reset release, WAIT_STATES=1: lw at addr 0x10 after sw 0xDEADBEEF to 0x10 -> d_ready high exactly 2 cycles after accept, d_rdata=0xDEADBEEF, d_err=0.
- Byte/half extension: RAM word 0x80F0_7F81 at 0x20; lb 0x20 -> 0xFFFFFF81; lbu 0x20 -> 0x00000081; lh 0x22 -> 0xFFFF80F0; lhu 0x22 -> 0x000080F0. Then sb 0x55 to 0x21 -> word reads 0x80F0_5581.
- Misaligned: sw 0x12345678 to 0x22 -> d_ready with d_err=1, d_rdata=0; subsequent lw 0x20 still returns 0x80F0_5581.
- MMIO: sw 0xA5A5_0003 to GPIO_ADDR -> gpio_out=0xA5A5_0003 on the RESP-entry edge. Two lw from CNT_ADDR separated by 10 cycles -> values differ by 10. sw to CNT_ADDR -> no error, counter unaffected.
- Back-to-back and held req: d_req held high across RESP -> only one transaction (one d_ready pulse), next accept no earlier than the IDLE cycle after RESP. WAIT_STATES=0 rerun -> d_ready 1 cycle after accept.
- Reset mid-transaction: assert reset during WAIT of sw 0x11111111 to 0x30 (previous content 0x0) -> d_ready=0, gpio_out=0 immediately; after release, lw 0x30 returns 0x00000000.
